write_back_arbiter: RTL and testbench

- Shares the single register-file write port between the main pipeline write-back result and a long-latency secondary unit (multiplier / multi-cycle ALU).
- Pipeline results always win except under starvation.
- Secondary results are queued in a small FIFO and written in free cycles.
- A bounded-wait counter forces a one-cycle pipeline stall so queued results cannot starve.
- Sits between the write-back stage output and the register file write port.

---
 rtl/write_back_arbiter_pkg.sv | 18 +
 rtl/wb_request_fifo.sv | 47 ++++
 rtl/write_back_arbiter.sv | 105 ++++++++++
 tb/tb_write_back_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/write_back_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// The widths match the register file and the write-back stage.
package write_back_arbiter_pkg;

    localparam int WB_DATA_WIDTH     = 32;
    localparam int WB_REG_ADDR_WIDTH = 4;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [WB_REG_ADDR_WIDTH-1:0] dest;
        logic [WB_DATA_WIDTH-1:0]     value;
    } wb_req_t;

endpackage

// File: rtl/wb_request_fifo.sv
// Small synchronous FIFO that holds pending secondary write requests.
// The pointers carry one extra wrap bit, so full and empty are told apart without a count.
module wb_request_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/write_back_arbiter.sv
// Arbitrates the single register-file write port between the pipeline and a queued secondary unit.
// A queue head that has waited MAX_WAIT cycles wins one cycle while the pipeline is stalled.
module write_back_arbiter
    import write_back_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = WB_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = WB_REG_ADDR_WIDTH,
    parameter int FIFO_DEPTH     = 2,
    parameter int MAX_WAIT       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wbValid,
    input  logic [REG_ADDR_WIDTH-1:0] wbDest,
    input  logic [DATA_WIDTH-1:0]     wbValue,
    input  logic                      secValid,
    output logic                      secReady,
    input  logic [REG_ADDR_WIDTH-1:0] secDest,
    input  logic [DATA_WIDTH-1:0]     secValue,
    output logic                      rfWriteEnable,
    output logic [REG_ADDR_WIDTH-1:0] rfWriteDest,
    output logic [DATA_WIDTH-1:0]     rfWriteValue,
    output logic                      pipelineStall,
    output logic                      queueEmpty,
    output wb_state_t                 fsm_state
);

    localparam int REQ_WIDTH = REG_ADDR_WIDTH + DATA_WIDTH;
    localparam int CW        = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

    wb_state_t            state;
    logic [CW-1:0]        wait_cnt;
    logic [CW-1:0]        wait_next;
    logic                 grant_pipe;
    logic                 grant_queue;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [REQ_WIDTH-1:0] fifo_head;

    // Secondary handshake: a result transfers at a rising edge where secValid && secReady.
    // secReady depends only on queue occupancy, so a full queue never accepts, even while draining.
    assign secReady   = !fifo_full;
    assign queueEmpty = fifo_empty;
    assign fsm_state  = state;

    wb_request_fifo #(
        .WIDTH (REQ_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (secValid),
        .wr_data ({secDest, secValue}),
        .rd_en   (grant_queue),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        grant_pipe  = (state == ST_NORMAL) && wbValid;
        grant_queue = !fifo_empty && ((state == ST_FORCE) || !wbValid);
        wait_next   = '0;
        if (state == ST_NORMAL && !fifo_empty && !grant_queue) begin
            wait_next = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_NORMAL;
            wait_cnt      <= '0;
            pipelineStall <= 1'b0;
            rfWriteEnable <= 1'b0;
            rfWriteDest   <= '0;
            rfWriteValue  <= '0;
        end else begin
            rfWriteEnable <= grant_pipe || grant_queue;
            if (grant_pipe) begin
                rfWriteDest  <= wbDest;
                rfWriteValue <= wbValue;
            end else if (grant_queue) begin
                rfWriteDest  <= fifo_head[REQ_WIDTH-1 -: REG_ADDR_WIDTH];
                rfWriteValue <= fifo_head[DATA_WIDTH-1:0];
            end
            wait_cnt <= wait_next;
            case (state)
                ST_NORMAL: begin
                    if (!fifo_empty && !grant_queue && wait_next == WAIT_LIMIT) begin
                        state         <= ST_FORCE;
                        pipelineStall <= 1'b1;
                    end else begin
                        pipelineStall <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_NORMAL;
                    pipelineStall <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_write_back_arbiter.sv
// Bench for write_back_arbiter: directed cases with literal expectations, then random traffic
// compared every cycle against a queue-based model of the arbitration rules.
module tb_write_back_arbiter;
    import write_back_arbiter_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 2;
    localparam int MAXW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wbValid = 1'b0;
    logic [AW-1:0] wbDest = '0;
    logic [DW-1:0] wbValue = '0;
    logic          secValid = 1'b1;
    logic          secReady;
    logic [AW-1:0] secDest = 4'd9;
    logic [DW-1:0] secValue = 32'h99;
    logic          rfWriteEnable;
    logic [AW-1:0] rfWriteDest;
    logic [DW-1:0] rfWriteValue;
    logic          pipelineStall;
    logic          queueEmpty;
    wb_state_t     fsm_state;

    write_back_arbiter #(
        .DATA_WIDTH     (DW),
        .REG_ADDR_WIDTH (AW),
        .FIFO_DEPTH     (DEPTH),
        .MAX_WAIT       (MAXW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wbValid       (wbValid),
        .wbDest        (wbDest),
        .wbValue       (wbValue),
        .secValid      (secValid),
        .secReady      (secReady),
        .secDest       (secDest),
        .secValue      (secValue),
        .rfWriteEnable (rfWriteEnable),
        .rfWriteDest   (rfWriteDest),
        .rfWriteValue  (rfWriteValue),
        .pipelineStall (pipelineStall),
        .queueEmpty    (queueEmpty),
        .fsm_state     (fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard model: pending secondary requests as {dest, value}
    logic [AW+DW-1:0] exp_q[$];
    int               waited  = 0;
    bit               forcing = 1'b0;
    bit               started = 1'b0;
    logic             exp_we = 1'b0;
    logic [AW-1:0]    exp_dest = '0;
    logic [DW-1:0]    exp_value = '0;
    logic             exp_stall = 1'b0;

    always @(posedge clk) begin
        logic [AW+DW-1:0] hd;
        bit accept;
        bit queue_served;
        int occ;
        started = 1'b1;
        if (rst) begin
            exp_q.delete();
            waited    = 0;
            forcing   = 1'b0;
            exp_we    = 1'b0;
            exp_dest  = '0;
            exp_value = '0;
            exp_stall = 1'b0;
        end else begin
            occ          = exp_q.size();
            accept       = secValid && (occ < DEPTH);
            queue_served = (occ > 0) && (forcing || !wbValid);
            if (queue_served) begin
                hd        = exp_q.pop_front();
                exp_we    = 1'b1;
                exp_dest  = hd[AW+DW-1:DW];
                exp_value = hd[DW-1:0];
            end else if (wbValid) begin
                exp_we    = 1'b1;
                exp_dest  = wbDest;
                exp_value = wbValue;
            end else begin
                exp_we = 1'b0;
            end
            if (!forcing && occ > 0 && !queue_served) begin
                waited = (waited < MAXW) ? waited + 1 : MAXW;
            end else begin
                waited = 0;
            end
            forcing   = !forcing && (waited == MAXW);
            if (forcing) waited = 0;
            exp_stall = forcing;
            if (accept) exp_q.push_back({secDest, secValue});
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("rfWriteEnable", 64'(rfWriteEnable), 64'(exp_we));
            check("rfWriteDest", 64'(rfWriteDest), 64'(exp_dest));
            check("rfWriteValue", 64'(rfWriteValue), 64'(exp_value));
            check("pipelineStall", 64'(pipelineStall), 64'(exp_stall));
            check("queueEmpty", 64'(queueEmpty), 64'(exp_q.size() == 0));
            check("secReady", 64'(secReady), 64'(exp_q.size() < DEPTH));
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wb(input logic v, input logic [AW-1:0] d, input logic [DW-1:0] x);
        wbValid = v;
        wbDest  = d;
        wbValue = x;
    endtask

    task automatic drive_sec(input logic v, input logic [AW-1:0] d, input logic [DW-1:0] x);
        secValid = v;
        secDest  = d;
        secValue = x;
    endtask

    initial begin
        // reset held two cycles with a secondary offer present
        step();
        step();
        check("reset_we", 64'(rfWriteEnable), 64'd0);
        check("reset_stall", 64'(pipelineStall), 64'd0);
        check("reset_empty", 64'(queueEmpty), 64'd1);
        check("reset_ready", 64'(secReady), 64'd1);
        rst = 1'b0;
        drive_sec(1'b0, '0, '0);

        // pipeline only
        drive_wb(1'b1, 4'd3, 32'hDEADBEEF);
        step();
        check("pipe_we", 64'(rfWriteEnable), 64'd1);
        check("pipe_dest", 64'(rfWriteDest), 64'd3);
        check("pipe_value", 64'(rfWriteValue), 64'hDEADBEEF);
        drive_wb(1'b0, '0, '0);

        // idle fill
        drive_sec(1'b1, 4'd5, 32'h12345678);
        step();
        drive_sec(1'b0, '0, '0);
        check("fill_notempty", 64'(queueEmpty), 64'd0);
        step();
        check("fill_we", 64'(rfWriteEnable), 64'd1);
        check("fill_dest", 64'(rfWriteDest), 64'd5);
        check("fill_value", 64'(rfWriteValue), 64'h12345678);
        check("fill_empty", 64'(queueEmpty), 64'd1);

        // contention with continuous pipeline traffic
        drive_wb(1'b1, 4'hE, 32'h0E0E);
        drive_sec(1'b1, 4'd7, 32'hA);
        step();
        drive_sec(1'b1, 4'd8, 32'hB);
        step();
        drive_sec(1'b0, '0, '0);
        check("cont_ready_low", 64'(secReady), 64'd0);
        step();
        check("cont_stall_w3", 64'(pipelineStall), 64'd0);
        check("cont_pipe_dest", 64'(rfWriteDest), 64'hE);
        step();
        check("cont_stall_w4", 64'(pipelineStall), 64'd0);
        step();
        check("cont_stall1", 64'(pipelineStall), 64'd1);
        check("cont_ready_full", 64'(secReady), 64'd0);
        step();
        check("cont_force1_we", 64'(rfWriteEnable), 64'd1);
        check("cont_force1_dest", 64'(rfWriteDest), 64'd7);
        check("cont_force1_value", 64'(rfWriteValue), 64'hA);
        check("cont_force1_unstall", 64'(pipelineStall), 64'd0);
        check("cont_ready_back", 64'(secReady), 64'd1);
        repeat (3) begin
            step();
            check("cont_no_early_stall", 64'(pipelineStall), 64'd0);
        end
        step();
        check("cont_stall2", 64'(pipelineStall), 64'd1);
        step();
        check("cont_force2_dest", 64'(rfWriteDest), 64'd8);
        check("cont_force2_value", 64'(rfWriteValue), 64'hB);
        check("cont_empty", 64'(queueEmpty), 64'd1);
        drive_wb(1'b0, '0, '0);
        step();

        // simultaneous pipeline request and enqueue on empty queue
        drive_wb(1'b1, 4'd1, 32'h1);
        drive_sec(1'b1, 4'd2, 32'h2);
        step();
        drive_wb(1'b0, '0, '0);
        drive_sec(1'b0, '0, '0);
        check("sim_dest1", 64'(rfWriteDest), 64'd1);
        check("sim_value1", 64'(rfWriteValue), 64'h1);
        step();
        check("sim_we2", 64'(rfWriteEnable), 64'd1);
        check("sim_dest2", 64'(rfWriteDest), 64'd2);
        check("sim_value2", 64'(rfWriteValue), 64'h2);
        check("sim_nostall", 64'(pipelineStall), 64'd0);
        step();

        // reset with two entries queued
        drive_wb(1'b1, 4'hC, 32'hC0C0);
        drive_sec(1'b1, 4'd4, 32'h44);
        step();
        drive_sec(1'b1, 4'd6, 32'h66);
        step();
        drive_sec(1'b0, '0, '0);
        check("rq_full", 64'(secReady), 64'd0);
        rst = 1'b1;
        drive_wb(1'b0, '0, '0);
        step();
        rst = 1'b0;
        check("rq_empty", 64'(queueEmpty), 64'd1);
        check("rq_we", 64'(rfWriteEnable), 64'd0);
        repeat (4) begin
            step();
            check("rq_no_write", 64'(rfWriteEnable), 64'd0);
        end

        // randomized traffic, checked each cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            int wb_pct;
            wb_pct = ((i / 250) % 3 == 0) ? 95 : (((i / 250) % 3 == 1) ? 50 : 15);
            rst = ($urandom_range(0, 299) == 0);
            drive_wb($urandom_range(0, 99) < wb_pct, AW'($urandom_range(0, 15)), $urandom);
            drive_sec($urandom_range(0, 99) < 40, AW'($urandom_range(0, 15)), $urandom);
            step();
        end
        rst = 1'b0;
        drive_wb(1'b0, '0, '0);
        drive_sec(1'b0, '0, '0);
        repeat (12) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
